cla_pipe_addsub: RTL and testbench
==================================

Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Splits WIDTH-bit operands into GROUP-bit lookahead groups and spreads the groups across STAGES register stages.
- Valid/ready handshake on both sides, so it can sit directly in the datapath between a producer (operand source) and a consumer (result sink).
- Adds subtract mode, signed-overflow and zero flags, and back-pressure.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GROUP.
- GROUP, 4, bits per carry-lookahead group (full generate/propagate lookahead inside a group).
- STAGES, 2, pipeline depth; 1 ≤ STAGES ≤ WIDTH/GROUP, and must divide WIDTH/GROUP.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: s=a+b+cin; 1: s=a-b (a+~b+1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out of MSB; in subtract mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  s == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, s, cout, ovf and zero clear to 0; partial sums and carries clear to 0. Deassertion is taken synchronously at the next clk edge.
- Reset mid-operation discards every in-flight beat; no result for those beats ever appears.
- Operand conditioning at input:
  - bb = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Group datapath:
  - Each group computes G = a&bb and P = a^bb, then lookahead carries c[i+1] = G[i] | P[i]&c[i], flattened within the group.
  - Group sum = P ^ c.
  - Group carry-out is passed to the next group.
- Stage k (0..STAGES-1) handles groups k*N .. k*N+N-1, where N = WIDTH/(GROUP*STAGES).
  - Groups within a stage chain their carries combinationally.
  - Between stages, the carry, the completed lower sum bits and the remaining unprocessed operand bits are registered (skewed pipeline).
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid=1 with that beat's result, assuming no stall.
- Throughput: one beat per cycle when out_ready=1.
- Stall rule:
  - advance = ~out_valid | out_ready; in_ready = advance (combinational).
  - When advance=0, every stage register holds its value; s, cout, ovf and zero stay stable while out_valid=1.
  - When advance=1, all stages shift by one. An empty stage propagates as a bubble (valid=0).
  - Beats are never dropped or duplicated, and ordering is preserved.
- Flags, computed in the final stage and registered with s:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR cout.
  - zero = (s == 0).
- in_valid=1 while in_ready=0: the beat is not taken; the producer must hold a, b, cin and sub stable.
- Output values while out_valid=0 are don't-care; the bench must not check them.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- Simultaneous accept and emit in the same cycle is legal and is the steady state.

Test Plan:
- Reset, then a=0x1234, b=0x4321, cin=0, sub=0 -> after 2 cycles: out_valid=1, s=0x5555, cout=0, ovf=0, zero=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> s=0x0000, cout=1, zero=1, ovf=0. The carry must ripple across the stage boundary.
- Subtract cases (sub=1):
  - a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1.
  - a=0x0003, b=0x0005 -> s=0xFFFE, cout=0, ovf=0.
- Stream 20 random beats with out_ready toggling pseudo-randomly -> output sequence matches a reference model in order, with no drops or duplicates. Whenever out_valid=1 and out_ready=0, s must hold its value and in_ready=0.
- Assert rst_n low for one cycle while 2 beats are in flight -> out_valid=0 immediately (asynchronous), and no stale result appears after release.
- Parameter sweep (WIDTH,GROUP,STAGES) = (8,4,1), (32,4,4), (32,8,2) -> exhaustive (8-bit) or 10k random vectors match a+b+cin / a-b; latency equals STAGES in each configuration.

Source files
------------

// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_addsub
// Purpose  : Pipelined carry-lookahead adder/subtractor with valid/ready
//            handshake on both sides, skewed across STAGES register stages.
//            Each stage resolves WIDTH/STAGES result bits as a chain of
//            GROUP-bit lookahead groups; the running carry, the finished low
//            sum bits and the not-yet-used operand bits travel down the pipe.
// Ports    : clk, rst_n (async active-low)
//            in_valid/in_ready, a, b, cin, sub  -- operand beat
//            out_valid/out_ready, s, cout, ovf, zero -- result beat
// Params   : WIDTH (multiple of GROUP), GROUP, STAGES (divides WIDTH/GROUP)
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGE_BITS       = WIDTH / STAGES;
  localparam int GROUPS_PER_STAGE = STAGE_BITS / GROUP;

  // The whole pipe moves as one: it only stalls when the result register
  // holds a beat the consumer has not taken yet.
  logic advance;

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q,   sum_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q,     a_d;
  logic [STAGES-1:0][WIDTH-1:0] bb_q,    bb_d;
  logic                         ovf_q,   ovf_d;
  logic                         zero_q,  zero_d;

  // Flattened lookahead: every carry inside the group is a sum-of-products
  // of G/P and the group carry-in, with no ripple between bits.
  // Returned vector: [0] = carry-in, [i] = carry into bit i, [GROUP] = carry-out.
  function automatic logic [GROUP:0] group_carries(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             ci
  );
    logic [GROUP:0] c;
    logic           term;
    logic           pp;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      term = g[i];
      pp   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i+1] = term | (pp & ci);
    end
    return c;
  endfunction

  assign advance  = ~valid_q[STAGES-1] | out_ready;
  assign in_ready = advance;

  always_comb begin
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_bb;
    logic [WIDTH-1:0] cur_sum;
    logic             cur_c;
    logic             cur_v;
    logic [WIDTH-1:0] stage_sum;
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             c_run;
    logic             c_msb;
    int               base;

    valid_d = '0;
    carry_d = '0;
    sum_d   = '0;
    a_d     = '0;
    bb_d    = '0;
    ovf_d   = 1'b0;
    zero_d  = 1'b0;

    // Subtraction is a + ~b + 1, so condition the operands once at the input.
    cur_a     = a;
    cur_bb    = sub ? ~b : b;
    cur_c     = sub ? 1'b1 : cin;
    cur_sum   = '0;
    cur_v     = in_valid;
    stage_sum = '0;
    g         = '0;
    p         = '0;
    c         = '0;
    c_run     = 1'b0;
    c_msb     = 1'b0;
    base      = 0;

    for (int k = 0; k < STAGES; k++) begin
      stage_sum = cur_sum;
      c_run     = cur_c;
      for (int grp = 0; grp < GROUPS_PER_STAGE; grp++) begin
        base  = k * STAGE_BITS + grp * GROUP;
        g     = cur_a[base +: GROUP] & cur_bb[base +: GROUP];
        p     = cur_a[base +: GROUP] ^ cur_bb[base +: GROUP];
        c     = group_carries(g, p, c_run);
        stage_sum[base +: GROUP] = p ^ c[GROUP-1:0];
        c_msb = c[GROUP-1];
        c_run = c[GROUP];
      end

      valid_d[k] = cur_v;
      carry_d[k] = c_run;
      sum_d[k]   = stage_sum;
      a_d[k]     = cur_a;
      bb_d[k]    = cur_bb;

      // The top group lives in the last stage, so both carries needed for
      // signed overflow are available right here.
      if (k == STAGES - 1) begin
        ovf_d  = c_msb ^ c_run;
        zero_d = ~|stage_sum;
      end

      cur_a   = a_q[k];
      cur_bb  = bb_q[k];
      cur_sum = sum_q[k];
      cur_c   = carry_q[k];
      cur_v   = valid_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      bb_q    <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (advance) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      bb_q    <= bb_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_pipe_addsub
// Purpose  : Self-checking bench for cla_pipe_addsub: directed vector table,
//            randomized back-pressure stream, mid-flight reset, and a
//            parameter sweep over three extra configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_addsub;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_sw_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;
  logic        zero;

  int checks;
  int errors;
  int sw_done_cnt;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(16), .GROUP(4), .STAGES(2)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed readings.
  function automatic exp_t ref_model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                     input logic ci, input logic sb);
    exp_t   e;
    longint m, lim, ua, ub, sa, sbv, r, sr;
    m   = (longint'(1) << w) - 1;
    lim = longint'(1) << (w - 1);
    ua  = longint'(ai) & m;
    ub  = longint'(bi) & m;
    sa  = (ua >= lim) ? ua - (m + 1) : ua;
    sbv = (ub >= lim) ? ub - (m + 1) : ub;
    if (sb) begin
      r      = ua - ub;
      sr     = sa - sbv;
      e.cout = (ua >= ub);
    end else begin
      r      = ua + ub + longint'(ci);
      sr     = sa + sbv + longint'(ci);
      e.cout = (r > m);
    end
    e.s    = 32'(r & m);
    e.zero = ((r & m) == 0);
    e.ovf  = (sr >= lim) || (sr < -lim);
    return e;
  endfunction

  // One isolated beat with out_ready high: latency and all result fields.
  task automatic run_one(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(n), 64'd2);
    check({tag, "_s"},    64'(s),    64'(v.s));
    check({tag, "_cout"}, 64'(cout), 64'(v.cout));
    check({tag, "_ovf"},  64'(ovf),  64'(v.ovf));
    check({tag, "_zero"}, 64'(zero), 64'(v.zero));
  endtask

  // -------------------------------------------------------------------------
  // Parameter sweep: three extra configurations, streamed at full rate.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W  = (gi == 0) ? 8 : 32;
    localparam int G  = (gi == 2) ? 8 : 4;
    localparam int S  = (gi == 0) ? 1 : ((gi == 1) ? 4 : 2);
    localparam int NV = (gi == 0) ? 65536 : 10000;

    logic         iv, ir, ov, ci, sb, co, of, zr;
    logic [W-1:0] aa, bv, ss;
    exp_t         q[$];
    exp_t         e;

    cla_pipe_addsub #(.WIDTH(W), .GROUP(G), .STAGES(S)) u_sw (
      .clk      (clk),
      .rst_n    (rst_sw_n),
      .in_valid (iv),
      .in_ready (ir),
      .a        (aa),
      .b        (bv),
      .cin      (ci),
      .sub      (sb),
      .out_valid(ov),
      .out_ready(1'b1),
      .s        (ss),
      .cout     (co),
      .ovf      (of),
      .zero     (zr)
    );

    initial begin
      int n;
      int i;
      int cyc;
      int rcv;
      iv = 1'b0; aa = '0; bv = '0; ci = 1'b0; sb = 1'b0;
      wait (rst_sw_n === 1'b1);
      // Latency probe: 5 - 3.
      @(negedge clk);
      aa = W'(5); bv = W'(3); sb = 1'b1; ci = 1'b0; iv = 1'b1;
      @(posedge clk);
      n = 1;
      @(negedge clk);
      iv = 1'b0;
      while (!ov && n < 20) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      check($sformatf("sw%0d_latency", gi), 64'(n), 64'(S));
      check($sformatf("sw%0d_latency_s", gi), 64'(ss), 64'd2);

      i = 0; cyc = 0; rcv = 0;
      while ((i < NV || q.size() != 0) && cyc < 80000) begin
        @(negedge clk);
        cyc++;
        if (ov) begin
          if (q.size() == 0) begin
            check($sformatf("sw%0d_extra_beat%0d", gi, rcv), 64'(ov), 64'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("sw%0d_beat%0d", gi, rcv),
                  {29'd0, 32'(ss), co, of, zr}, {29'd0, e.s, e.cout, e.ovf, e.zero});
          end
          rcv++;
        end
        if (i < NV) begin
          if (gi == 0) begin
            aa = W'(i);
            bv = W'(i >> 8);
            sb = ((i % 3) == 2);
            ci = ((i % 3) == 1);
          end else begin
            aa = W'($urandom);
            bv = W'($urandom);
            sb = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
          end
          iv = 1'b1;
          q.push_back(ref_model(W, 32'(aa), 32'(bv), ci, sb));
          i++;
        end else begin
          iv = 1'b0;
        end
      end
      check($sformatf("sw%0d_drained", gi), 64'(q.size()), 64'd0);
      sw_done_cnt++;
    end
  end

  // -------------------------------------------------------------------------
  // Main sequence on the default configuration.
  // -------------------------------------------------------------------------
  initial begin
    vec_t tbl [10];
    exp_t mq[$];
    exp_t e;
    int   sent, recv, cyc;
    logic acc_prev, prev_stall;
    logic [18:0] prev_bits;

    checks = 0; errors = 0; sw_done_cnt = 0;
    rst_n = 1'b0; rst_sw_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'h5A5A, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_s",         64'(s),         64'd0);
    check("rst_flags",     64'({cout, ovf, zero}), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    rst_n = 1'b1; rst_sw_n = 1'b1;

    for (int i = 0; i < 10; i++) run_one(tbl[i], $sformatf("vec%0d", i));

    // Random stream with pseudo-random back-pressure.
    sent = 0; recv = 0; cyc = 0; acc_prev = 1'b0; prev_stall = 1'b0; prev_bits = '0;
    @(negedge clk);
    while (recv < 20 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (acc_prev) in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      #1;
      if (prev_stall) begin
        check("stall_valid_held", 64'(out_valid), 64'd1);
        check("stall_result_held", 64'({s, cout, ovf, zero}), 64'(prev_bits));
      end
      if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (mq.size() == 0) begin
          check($sformatf("stream_extra%0d", recv), 64'(out_valid), 64'd0);
        end else begin
          e = mq.pop_front();
          check($sformatf("stream_beat%0d", recv), {45'd0, s, cout, ovf, zero},
                {45'd0, e.s[15:0], e.cout, e.ovf, e.zero});
        end
        recv++;
      end
      acc_prev = in_valid && in_ready;
      if (acc_prev) begin
        mq.push_back(ref_model(16, {16'd0, a}, {16'd0, b}, cin, sub));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_bits  = {s, cout, ovf, zero};
    end
    check("stream_received", 64'(recv), 64'd20);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("stream_no_dup%0d", i), 64'(out_valid), 64'd0);
    end

    // Reset with two beats in flight (one at the output, one in stage 0).
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    a = 16'h3333; b = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    check("flight_out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_s", 64'(s), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_no_stale%0d", i), 64'(out_valid), 64'd0);
    end
    run_one('{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0}, "post_rst");

    cyc = 0;
    while (sw_done_cnt < 3 && cyc < 90000) begin
      @(posedge clk);
      cyc++;
    end
    check("sweeps_done", 64'(sw_done_cnt), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
